// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, port owner,
// memory access fields and the fetch/data arbitration rule.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic                    we;
    logic [DATA_W_DEF/8-1:0] be;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wdata;
  } mem_req_t;

  // DM has priority unless it also took the previous grant and IF is waiting.
  function automatic owner_e arb_pick(input logic if_req, input logic dm_req,
                                      input logic last_dm);
    if (dm_req && !(if_req && last_dm)) return OWN_DM;
    return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory handshake seen by the
// arbiter; master = arbiter side, slave = core + memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;
  logic              stall;

  modport master (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output err, stall
  );

  modport slave (
    output if_req, if_addr,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  err, stall
  );

endinterface

// File: rtl/arb_perf_counter.sv
// Free-running 32-bit event counter with enable; wraps at 2^CNT_W.
module arb_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)       r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-port
// memory (IDLE -> BUSY -> RESP). Optional macro ARB_PERF_CNT_EN adds grant/stall counters.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  mem_port_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_if_cnt,
  output logic [31:0]        perf_dm_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e        r_state,     w_state;
  owner_e            r_owner,     w_owner,  w_pick;
  logic              r_last_dm,   w_last_dm;
  logic              r_mem_req,   w_mem_req;
  logic              r_mem_we,    w_mem_we;
  logic [BE_W-1:0]   r_mem_be,    w_mem_be;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic              r_if_gnt,    w_if_gnt;
  logic              r_dm_gnt,    w_dm_gnt;
  logic              r_if_rvalid, w_if_rvalid;
  logic              r_dm_rvalid, w_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata,  w_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata,  w_dm_rdata;
  logic              r_err,       w_err;
  logic [CNT_W-1:0]  r_cnt,       w_cnt;
  logic              w_resp;
  logic [DATA_W-1:0] w_resp_data;
  logic              w_stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_last_dm   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_last_dm   <= w_last_dm;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_be    <= w_mem_be;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_if_gnt    <= w_if_gnt;
      r_dm_gnt    <= w_dm_gnt;
      r_if_rvalid <= w_if_rvalid;
      r_dm_rvalid <= w_dm_rvalid;
      r_if_rdata  <= w_if_rdata;
      r_dm_rdata  <= w_dm_rdata;
      r_err       <= w_err;
      r_cnt       <= w_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_last_dm   = r_last_dm;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_be    = r_mem_be;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_if_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    w_if_rvalid = 1'b0;
    w_dm_rvalid = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_dm_rdata  = r_dm_rdata;
    w_err       = 1'b0;
    w_cnt       = r_cnt;
    w_resp      = 1'b0;
    w_resp_data = '0;
    w_pick      = arb_pick(bus.if_req, bus.dm_req, r_last_dm);

    case (r_state)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          w_state   = BUSY;
          w_owner   = w_pick;
          w_last_dm = (w_pick == OWN_DM);
          w_mem_req = 1'b1;
          w_cnt     = '0;
          if (w_pick == OWN_DM) begin
            w_dm_gnt    = 1'b1;
            w_mem_we    = bus.dm_we;
            w_mem_be    = bus.dm_be;
            w_mem_addr  = bus.dm_addr;
            w_mem_wdata = bus.dm_wdata;
          end else begin
            w_if_gnt    = 1'b1;
            w_mem_we    = 1'b0;
            w_mem_be    = '1;
            w_mem_addr  = bus.if_addr;
            w_mem_wdata = '0;
          end
        end
      end
      BUSY: begin
        // An ack on the final allowed cycle still completes normally.
        if (bus.mem_ack) begin
          w_resp      = 1'b1;
          w_resp_data = r_mem_we ? '0 : bus.mem_rdata;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_resp = 1'b1;
          w_err  = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase

    if (w_resp) begin
      w_state   = RESP;
      w_mem_req = 1'b0;
      if (r_owner == OWN_DM) begin
        w_dm_rvalid = 1'b1;
        w_dm_rdata  = w_resp_data;
      end else begin
        w_if_rvalid = 1'b1;
        w_if_rdata  = w_resp_data;
      end
    end
  end

  assign w_stall = (bus.if_req & ~r_if_rvalid) | (bus.dm_req & ~r_dm_rvalid);

  assign bus.if_gnt    = r_if_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_gnt    = r_dm_gnt;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.err       = r_err;
  assign bus.stall     = w_stall;

`ifdef ARB_PERF_CNT_EN
  arb_perf_counter #(.CNT_W(32)) u_perf_if (
    .clk(CLK), .rst(RST), .i_en(r_if_gnt), .o_cnt(perf_if_cnt)
  );
  arb_perf_counter #(.CNT_W(32)) u_perf_dm (
    .clk(CLK), .rst(RST), .i_en(r_dm_gnt), .o_cnt(perf_dm_cnt)
  );
  arb_perf_counter #(.CNT_W(32)) u_perf_stall (
    .clk(CLK), .rst(RST), .i_en(w_stall), .o_cnt(perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants and responses are queued at
// issue time and checked by an independent monitor.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_cnt, perf_dm_cnt, perf_stall_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_cnt(perf_if_cnt),
    .perf_dm_cnt(perf_dm_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct { owner_e own; mem_req_t f; } gnt_exp_t;
  typedef struct { owner_e own; logic [31:0] rdata; logic err; } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];
  gnt_exp_t mon_g;
  rsp_exp_t mon_r;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return {a[15:0], 16'hBEEF};
  endfunction

  task automatic push_gnt(input owner_e o, input logic we, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] wd);
    gnt_exp_t g;
    g.own = o; g.f.we = we; g.f.be = be; g.f.addr = a; g.f.wdata = wd;
    gq.push_back(g);
  endtask

  task automatic push_rsp(input owner_e o, input logic [31:0] d, input logic e);
    rsp_exp_t r;
    r.own = o; r.rdata = d; r.err = e;
    rq.push_back(r);
  endtask

  // which: 0 dm_gnt, 1 mem_ack, 2 mem_req, 3 if_rvalid
  task automatic wait_sig(input int which, input int cap, input string name);
    logic s;
    for (int i = 0; i < cap; i++) begin
      @(negedge CLK);
      case (which)
        0:       s = bus.dm_gnt;
        1:       s = bus.mem_ack;
        2:       s = bus.mem_req;
        default: s = bus.if_rvalid;
      endcase
      if (s) return;
    end
    checks++;
    errors++;
    $display("FAIL %s wait expired actual=0 required=1", name);
  endtask

  // Memory model: acks ack_delay cycles after mem_req rises; manual ack when disabled.
  int   ack_delay = 0;
  bit   ack_en    = 1'b1;
  logic force_ack = 1'b0;
  int   wait_cnt  = 0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge CLK);
      #1;
      if (ack_en) begin
        if (bus.mem_req && !bus.mem_ack) begin
          if (wait_cnt >= ack_delay) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_val(bus.mem_addr);
            wait_cnt      = 0;
          end else begin
            wait_cnt++;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
          end
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 32'hDEAD_BEEF;
          wait_cnt      = 0;
        end
      end else begin
        bus.mem_ack   = force_ack;
        bus.mem_rdata = 32'hDEAD_BEEF;
        wait_cnt      = 0;
      end
    end
  end

  // Monitor
  always @(negedge CLK) begin
    if (bus.if_gnt || bus.dm_gnt) begin
      if (gq.size() == 0) begin
        checks++; errors++;
        $display("FAIL gnt_unexpected actual=%b%b required=00", bus.dm_gnt, bus.if_gnt);
      end else begin
        mon_g = gq.pop_front();
        chk("gnt_owner", 128'({bus.dm_gnt, bus.if_gnt}),
            128'((mon_g.own == OWN_DM) ? 2'b10 : 2'b01));
        chk("gnt_fields", 128'({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}),
            128'(mon_g.f));
        chk("gnt_mem_req", 128'(bus.mem_req), 128'(1));
      end
    end
    if (bus.if_rvalid || bus.dm_rvalid) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected actual=%b%b required=00", bus.dm_rvalid, bus.if_rvalid);
      end else begin
        mon_r = rq.pop_front();
        chk("rsp_owner", 128'({bus.dm_rvalid, bus.if_rvalid}),
            128'((mon_r.own == OWN_DM) ? 2'b10 : 2'b01));
        chk("rsp_rdata", 128'((mon_r.own == OWN_DM) ? bus.dm_rdata : bus.if_rdata),
            128'(mon_r.rdata));
        chk("rsp_err", 128'(bus.err), 128'(mon_r.err));
      end
    end else if (bus.err) begin
      checks++; errors++;
      $display("FAIL err_without_rvalid actual=1 required=0");
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    logic acc;
    int if_left, dm_left;
    logic if_rv, dm_rv;

    RST = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0;
    bus.dm_addr = '0;  bus.dm_wdata = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ctrl", 128'({bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid,
                          bus.err, bus.mem_req, bus.stall}), 128'(0));
    chk("rst_fields", 128'({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}), 128'(0));
    chk("rst_rdata", 128'({bus.if_rdata, bus.dm_rdata}), 128'(0));
`ifdef ARB_PERF_CNT_EN
    chk("rst_perf", 128'({perf_if_cnt, perf_dm_cnt, perf_stall_cnt}), 128'(0));
`endif
    @(posedge CLK); #1; RST = 1'b0;
    repeat (2) @(posedge CLK);

    // Test 1: IF only, ack one cycle after mem_req
    ack_delay = 1;
    #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    push_gnt(OWN_IF, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    push_rsp(OWN_IF, 32'h0050_0093, 1'b0);
    @(negedge CLK);
    chk("t1_c0 gnt/rv/mreq/stall", 128'({bus.if_gnt, bus.if_rvalid, bus.mem_req, bus.stall}), 128'(4'b0001));
    @(negedge CLK);
    chk("t1_c1 gnt/rv/mreq/stall", 128'({bus.if_gnt, bus.if_rvalid, bus.mem_req, bus.stall}), 128'(4'b1011));
    @(negedge CLK);
    chk("t1_c2 gnt/rv/mreq/stall", 128'({bus.if_gnt, bus.if_rvalid, bus.mem_req, bus.stall}), 128'(4'b0011));
    @(negedge CLK);
    chk("t1_c3 gnt/rv/mreq/stall", 128'({bus.if_gnt, bus.if_rvalid, bus.mem_req, bus.stall}), 128'(4'b0100));
    @(posedge CLK); #1;
    bus.if_req = 1'b0;
    @(negedge CLK);
    chk("t1_c4 gnt/rv/mreq/stall", 128'({bus.if_gnt, bus.if_rvalid, bus.mem_req, bus.stall}), 128'(4'b0000));

    // Test 2: both held, DM first then alternating
    ack_delay = 0;
    @(posedge CLK); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0020;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF;
    bus.dm_addr = 32'h0000_0100; bus.dm_wdata = 32'h0;
    push_gnt(OWN_DM, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    push_rsp(OWN_DM, 32'h0100_BEEF, 1'b0);
    push_gnt(OWN_IF, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    push_rsp(OWN_IF, 32'h0020_BEEF, 1'b0);
    push_gnt(OWN_DM, 1'b0, 4'hF, 32'h0000_0104, 32'h0);
    push_rsp(OWN_DM, 32'h0104_BEEF, 1'b0);
    push_gnt(OWN_IF, 1'b0, 4'hF, 32'h0000_0024, 32'h0);
    push_rsp(OWN_IF, 32'h0024_BEEF, 1'b0);
    if_left = 2; dm_left = 2; n = 0;
    while ((if_left > 0 || dm_left > 0) && n < 60) begin
      @(negedge CLK);
      if_rv = bus.if_rvalid; dm_rv = bus.dm_rvalid;
      @(posedge CLK); #1;
      if (dm_rv) begin
        dm_left--; bus.dm_addr = bus.dm_addr + 32'd4;
        if (dm_left == 0) bus.dm_req = 1'b0;
      end
      if (if_rv) begin
        if_left--; bus.if_addr = bus.if_addr + 32'd4;
        if (if_left == 0) bus.if_req = 1'b0;
      end
      n++;
    end
    chk("t2_all_served", 128'({if_left[7:0], dm_left[7:0]}), 128'(0));
    @(negedge CLK);
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_if", 128'(perf_if_cnt), 128'(3));
    chk("t6_perf_dm", 128'(perf_dm_cnt), 128'(2));
    chk("t6_perf_stall", 128'(perf_stall_cnt), 128'(14));
`endif

    // Test 3: store, fields latched at grant, rvalid one cycle after ack
    ack_delay = 2;
    @(posedge CLK); #1;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'b0011;
    bus.dm_addr = 32'h0000_0200; bus.dm_wdata = 32'hAAAA_5555;
    push_gnt(OWN_DM, 1'b1, 4'b0011, 32'h0000_0200, 32'hAAAA_5555);
    push_rsp(OWN_DM, 32'h0, 1'b0);
    wait_sig(0, 5, "t3_dm_gnt");
    @(posedge CLK); #1;
    bus.dm_wdata = 32'h1234_5678; bus.dm_addr = 32'h0000_0999; bus.dm_be = 4'hF;
    wait_sig(1, 10, "t3_mem_ack");
    chk("t3_latched", 128'({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}),
        128'({1'b1, 4'b0011, 32'h0000_0200, 32'hAAAA_5555}));
    chk("t3_no_early_rvalid", 128'(bus.dm_rvalid), 128'(0));
    @(negedge CLK);
    chk("t3_rvalid_after_ack", 128'({bus.dm_rvalid, bus.mem_req}), 128'(2'b10));
    @(posedge CLK); #1;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = 4'hF;
    bus.dm_addr = 32'h0000_0300; bus.dm_wdata = 32'h0;
    @(negedge CLK);

    // Test 4: no ack -> timeout abort after 15 BUSY cycles
    ack_en = 1'b0; force_ack = 1'b0;
    @(posedge CLK); #1;
    bus.dm_req = 1'b1;
    push_gnt(OWN_DM, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
    push_rsp(OWN_DM, 32'h0, 1'b1);
    wait_sig(2, 5, "t4_mem_req");
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      @(negedge CLK);
    end
    chk("t4_busy_cycles", 128'(n), 128'(15));
    chk("t4_abort mreq/rv/err", 128'({bus.mem_req, bus.dm_rvalid, bus.err}), 128'(3'b011));
    ack_en = 1'b1; ack_delay = 0;
    @(posedge CLK); #1;
    bus.dm_req = 1'b0;
    @(posedge CLK); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    push_gnt(OWN_IF, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    push_rsp(OWN_IF, 32'h0050_0093, 1'b0);
    wait_sig(3, 10, "t4_recover_rvalid");
    @(posedge CLK); #1;
    bus.if_req = 1'b0;
    @(negedge CLK);

    // Test 5: reset during BUSY, late ack ignored
    ack_en = 1'b0; force_ack = 1'b0;
    @(posedge CLK); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    push_gnt(OWN_IF, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_busy", 128'(bus.mem_req), 128'(1));
    @(posedge CLK); #1;
    RST = 1'b1; bus.if_req = 1'b0;
    @(negedge CLK);
    chk("t5_rst_not_yet", 128'(bus.mem_req), 128'(1));
    @(negedge CLK);
    chk("t5_rst_abort", 128'({bus.mem_req, bus.if_rvalid, bus.dm_rvalid, bus.err,
                              bus.if_gnt, bus.dm_gnt}), 128'(0));
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_rst", 128'({perf_if_cnt, perf_dm_cnt, perf_stall_cnt}), 128'(0));
`endif
    force_ack = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    force_ack = 1'b0;
    acc = bus.mem_ack;
    chk("t5_late_ack_seen", 128'(acc), 128'(1));
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = acc | bus.mem_req | bus.if_rvalid | bus.dm_rvalid | bus.err;
      @(negedge CLK);
    end
    chk("t5_ack_ignored", 128'(acc), 128'(0));
    ack_en = 1'b1;

    // Scoreboard must be drained
    repeat (3) @(negedge CLK);
    chk("sb_gnt_drained", 128'(gq.size()), 128'(0));
    chk("sb_rsp_drained", 128'(rq.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
